// File: rtl/team_06_audio_pkg.sv
// Shared types and constants for the audio level meter.
package team_06_audio_pkg;

  localparam int unsigned SAMPLE_W   = 8;
  localparam int unsigned LEVELS_DEF = 8;

  typedef logic [SAMPLE_W-1:0] level_t;

  function automatic level_t max_level(input level_t a, input level_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/team_06_rise_detect.sv
// Single-bit rising-edge detector; the history register takes RESET_VAL on reset and clear.
module team_06_rise_detect #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic d_i,
  output logic rise_c_o
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     d_q <= RESET_VAL;
    else if (clr_i) d_q <= RESET_VAL;
    else            d_q <= d_i;
  end

  assign rise_c_o = d_i & ~d_q;

endmodule

// File: rtl/team_06_audio_level_meter.sv
// Windowed average and held/decaying peak of 8-bit magnitude samples,
// with thermometer and one-hot bar codes for the LED display.
module team_06_audio_level_meter
  import team_06_audio_pkg::*;
#(
  parameter int unsigned WINDOW_LOG2  = 5,
  parameter int unsigned HOLD_WINDOWS = 8,
  parameter int unsigned DECAY_STEP   = 16,
  parameter int unsigned LEVELS       = LEVELS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  level_t            sample_in,
  input  logic              sample_valid,
  input  logic              clear,
  output level_t            avg_level,
  output level_t            peak_level,
  output logic [LEVELS-1:0] bar,
  output logic [LEVELS-1:0] peak_bar,
  output logic              window_done
);

  localparam int unsigned ACC_W  = SAMPLE_W + WINDOW_LOG2;
  localparam int unsigned HOLD_W = $clog2(HOLD_WINDOWS + 1);
  localparam int unsigned STEP   = 256 / LEVELS;

  logic [ACC_W-1:0]       acc_q, acc_d, sum;
  logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
  level_t                 win_max_q, win_max_d;
  level_t                 avg_q, avg_d, peak_q, peak_d;
  level_t                 m, avg_new, decayed;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   done_q, done_d;
  logic                   rise, accept;
  logic [LEVELS-1:0]      bar_c, peak_therm, peak_bar_c;

  // Edge history starts high so a valid already asserted at reset release is ignored.
  team_06_rise_detect #(.RESET_VAL(1'b1)) u_valid_rise (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (clear),
    .d_i      (sample_valid),
    .rise_c_o (rise)
  );

  assign accept = rise & ~clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      win_max_q <= '0;
      avg_q     <= '0;
      peak_q    <= '0;
      hold_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      win_max_q <= win_max_d;
      avg_q     <= avg_d;
      peak_q    <= peak_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    win_max_d = win_max_q;
    avg_d     = avg_q;
    peak_d    = peak_q;
    hold_d    = hold_q;
    done_d    = 1'b0;

    sum     = acc_q + ACC_W'(sample_in);
    m       = max_level(win_max_q, sample_in);
    avg_new = SAMPLE_W'(sum >> WINDOW_LOG2);
    decayed = ({1'b0, peak_q} > 9'(DECAY_STEP)) ? peak_q - SAMPLE_W'(DECAY_STEP) : '0;

    if (clear) begin
      acc_d     = '0;
      cnt_d     = '0;
      win_max_d = '0;
      avg_d     = '0;
      peak_d    = '0;
      hold_d    = '0;
    end else if (accept) begin
      if (cnt_q == '1) begin
        // Window end: publish the mean and update the peak tracker.
        avg_d     = avg_new;
        acc_d     = '0;
        cnt_d     = '0;
        win_max_d = '0;
        done_d    = 1'b1;
        if (m >= peak_q) begin
          peak_d = m;
          hold_d = HOLD_W'(HOLD_WINDOWS);
        end else if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
        end else begin
          peak_d = max_level(decayed, avg_new);
        end
      end else begin
        acc_d     = sum;
        cnt_d     = cnt_q + WINDOW_LOG2'(1);
        win_max_d = m;
      end
    end

    for (int unsigned i = 0; i < LEVELS; i++) begin
      bar_c[i]      = ({1'b0, avg_q}  > 9'(i * STEP));
      peak_therm[i] = ({1'b0, peak_q} > 9'(i * STEP));
    end
    // Top bit of the peak thermometer code.
    peak_bar_c = peak_therm & ~(peak_therm >> 1);
  end

  assign avg_level   = avg_q;
  assign peak_level  = peak_q;
  assign window_done = done_q;
  assign bar         = bar_c;
  assign peak_bar    = peak_bar_c;

endmodule

// File: tb/tb_team_06_audio_level_meter.sv
// Directed bench for team_06_audio_level_meter: window vectors from a table plus
// hand-written reset, clear, decay and pulse-timing sequences.
module tb_team_06_audio_level_meter;

  typedef struct {
    logic [7:0] fill;
    logic [7:0] last;
    int         hold;
    logic [7:0] avg;
    logic [7:0] bar;
    logic [7:0] peak;
    logic [7:0] pbar;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] avg_level, peak_level, bar, peak_bar;
  logic       window_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  team_06_audio_level_meter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .clear        (clear),
    .avg_level    (avg_level),
    .peak_level   (peak_level),
    .bar          (bar),
    .peak_bar     (peak_bar),
    .window_done  (window_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (window_done) done_cnt = done_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] v, input int hold);
    sample_in    = v;
    sample_valid = 1'b1;
    tick(hold);
    sample_valid = 1'b0;
    tick(2);
  endtask

  task automatic send_n(input logic [7:0] v, input int n, input int hold);
    for (int k = 0; k < n; k++) send(v, hold);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    sample_valid = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    done_cnt = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_avg"},  int'(avg_level),  0);
    check({tag, "_peak"}, int'(peak_level), 0);
    check({tag, "_bar"},  int'(bar),        0);
    check({tag, "_pbar"}, int'(peak_bar),   0);
    check({tag, "_done"}, int'(window_done), 0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{fill: 8'd100, last: 8'd100, hold: 1,  avg: 8'd100, bar: 8'h0F, peak: 8'd100, pbar: 8'h08};
    vecs[1] = '{fill: 8'd255, last: 8'd255, hold: 20, avg: 8'd255, bar: 8'hFF, peak: 8'd255, pbar: 8'h80};
    vecs[2] = '{fill: 8'd0,   last: 8'd255, hold: 1,  avg: 8'd7,   bar: 8'h01, peak: 8'd255, pbar: 8'h80};
    vecs[3] = '{fill: 8'd64,  last: 8'd64,  hold: 3,  avg: 8'd64,  bar: 8'h03, peak: 8'd64,  pbar: 8'h02};
    vecs[4] = '{fill: 8'd50,  last: 8'd50,  hold: 1,  avg: 8'd50,  bar: 8'h03, peak: 8'd50,  pbar: 8'h02};
    vecs[5] = '{fill: 8'd0,   last: 8'd0,   hold: 1,  avg: 8'd0,   bar: 8'h00, peak: 8'd0,   pbar: 8'h00};
    vecs[6] = '{fill: 8'd33,  last: 8'd33,  hold: 2,  avg: 8'd33,  bar: 8'h03, peak: 8'd33,  pbar: 8'h02};
    vecs[7] = '{fill: 8'd32,  last: 8'd32,  hold: 1,  avg: 8'd32,  bar: 8'h01, peak: 8'd32,  pbar: 8'h01};

    tick(1);
    check_zero("reset");
    rst_n = 1'b1;
    tick(1);

    // Table-driven windows, each from a fresh reset.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      send_n(vecs[v].fill, 31, vecs[v].hold);
      check($sformatf("v%0d_pre_avg", v), int'(avg_level), 0);
      check($sformatf("v%0d_pre_done", v), done_cnt, 0);
      send(vecs[v].last, vecs[v].hold);
      check($sformatf("v%0d_avg", v),  int'(avg_level),  int'(vecs[v].avg));
      check($sformatf("v%0d_bar", v),  int'(bar),        int'(vecs[v].bar));
      check($sformatf("v%0d_peak", v), int'(peak_level), int'(vecs[v].peak));
      check($sformatf("v%0d_pbar", v), int'(peak_bar),   int'(vecs[v].pbar));
      check($sformatf("v%0d_ndone", v), done_cnt, 1);
    end

    // window_done timing: high exactly one cycle right after the last accept.
    do_reset();
    send_n(8'd10, 31, 1);
    sample_in = 8'd10;
    sample_valid = 1'b1;
    tick(1);
    check("pulse_hi", int'(window_done), 1);
    check("pulse_avg", int'(avg_level), 10);
    tick(1);
    check("pulse_lo", int'(window_done), 0);
    sample_valid = 1'b0;
    tick(2);
    check("pulse_cnt", done_cnt, 1);

    // Hold then linear decay of the peak.
    do_reset();
    send_n(8'd200, 32, 1);
    check("decay_start", int'(peak_level), 200);
    for (int w = 1; w <= 22; w++) begin
      int exp_pk;
      send_n(8'd0, 32, 1);
      if (w <= 8) exp_pk = 200;
      else exp_pk = (200 - 16 * (w - 8) > 0) ? 200 - 16 * (w - 8) : 0;
      check($sformatf("decay_w%0d_peak", w), int'(peak_level), exp_pk);
      check($sformatf("decay_w%0d_avg", w),  int'(avg_level),  0);
    end

    // Reset in mid-window discards the partial window.
    do_reset();
    send_n(8'd100, 32, 1);
    send_n(8'd255, 10, 1);
    rst_n = 1'b0;
    #1;
    check_zero("midrst_async");
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check_zero("midrst");
    done_cnt = 0;
    send_n(8'd64, 32, 1);
    check("midrst_avg", int'(avg_level), 64);
    check("midrst_bar", int'(bar), 8'h03);
    check("midrst_ndone", done_cnt, 1);

    // Clear coinciding with a rising edge drops that sample.
    do_reset();
    send_n(8'd100, 32, 1);
    send_n(8'd200, 5, 1);
    sample_in = 8'd255;
    sample_valid = 1'b1;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(2);
    sample_valid = 1'b0;
    tick(2);
    check_zero("clr");
    done_cnt = 0;
    send_n(8'd50, 31, 1);
    check("clr_31_done", done_cnt, 0);
    check("clr_31_avg", int'(avg_level), 0);
    send(8'd50, 1);
    check("clr_32_avg", int'(avg_level), 50);
    check("clr_32_done", done_cnt, 1);

    // Valid already high at reset release is not an accept.
    rst_n = 1'b0;
    sample_in = 8'd255;
    sample_valid = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    sample_valid = 1'b0;
    tick(2);
    done_cnt = 0;
    send_n(8'd0, 31, 1);
    check("rel_31_done", done_cnt, 0);
    send(8'd0, 1);
    check("rel_32_done", done_cnt, 1);
    check("rel_avg", int'(avg_level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
